// File: rtl/relogio_pkg.sv
// Shared types and limits for the clock mode/set controller.
// RELOGIO_ALARM_EN extends the mode ring with the two alarm-setting states.
package relogio_pkg;

    typedef enum logic [2:0] {
        RUN         = 3'd0,
        SET_HOUR    = 3'd1,
        SET_MIN     = 3'd2,
        SET_AL_HOUR = 3'd3,
        SET_AL_MIN  = 3'd4
    } ctrl_state_e;

    localparam logic [5:0] MAX_MIN  = 6'd59;
    localparam logic [4:0] MAX_HORA = 5'd23;

    // Order of the mode ring; the last SET state always falls back to RUN.
    function automatic ctrl_state_e next_mode(input ctrl_state_e s);
        case (s)
            RUN:         next_mode = SET_HOUR;
            SET_HOUR:    next_mode = SET_MIN;
`ifdef RELOGIO_ALARM_EN
            SET_MIN:     next_mode = SET_AL_HOUR;
            SET_AL_HOUR: next_mode = SET_AL_MIN;
`endif
            default:     next_mode = RUN;
        endcase
    endfunction

endpackage

// File: rtl/relogio_ctrl_btn_edge.sv
// Push-button front end: one sample register, rising-edge detect and an
// optional hold auto-repeat (one pulse per tick once held HOLD_SECS ticks).
module btn_edge #(
    parameter int HOLD_SECS = 2,
    parameter bit REPEAT_EN = 1'b1
) (
    input  logic clk_1Hz,
    input  logic rstn_i,
    input  logic btn_i,
    input  logic hold_clr_i,
    output logic edge_o,
    output logic pulse_o
);

    logic cur_q;
    logic prev_q;

    always_ff @(posedge clk_1Hz or negedge rstn_i) begin
        if (!rstn_i) begin
            cur_q  <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            cur_q  <= btn_i;
            prev_q <= cur_q;
        end
    end

    assign edge_o = cur_q & ~prev_q;

    generate
        if (REPEAT_EN) begin : g_rep
            localparam int HW = $clog2(HOLD_SECS + 1);
            logic [HW-1:0] hold_q;

            // Saturating count of consecutive high samples; repeat fires once saturated.
            always_ff @(posedge clk_1Hz or negedge rstn_i) begin
                if (!rstn_i) begin
                    hold_q <= '0;
                end else if (!cur_q || hold_clr_i) begin
                    hold_q <= '0;
                end else if (hold_q != HW'(HOLD_SECS)) begin
                    hold_q <= hold_q + HW'(1);
                end
            end

            assign pulse_o = edge_o | (cur_q & prev_q & (hold_q == HW'(HOLD_SECS)));
        end else begin : g_norep
            logic unused_hold_clr;
            assign unused_hold_clr = hold_clr_i;
            assign pulse_o         = edge_o;
        end
    endgenerate

endmodule

// File: rtl/relogio_ctrl.sv
// Mode/set controller for the HH:MM:SS clock: seconds enable/clear, minute and
// hour increment strobes, blink and (with RELOGIO_ALARM_EN) the alarm flag.
module relogio_ctrl
    import relogio_pkg::*;
#(
    parameter int HOLD_SECS    = 2,
    parameter int TIMEOUT_SECS = 30
) (
    input  logic       clk_1Hz,
    input  logic       rstn_i,
    input  logic       mode_i,
    input  logic       inc_i,
    input  logic       inc_min_i,
    input  logic [5:0] minutos_i,
    input  logic [4:0] horas_i,
    output logic       sec_en_o,
    output logic       sec_clr_o,
    output logic       inc_min_o,
    output logic       inc_hour_o,
    output logic [2:0] state_o,
    output logic       blink_o,
    output logic       alarm_o
);

    localparam int TW = $clog2(TIMEOUT_SECS + 1);

    ctrl_state_e   state_q;
    ctrl_state_e   state_nxt;
    logic          mode_e;
    logic          inc_e;
    logic          inc_p;
    logic          timeout_hit;
    logic          state_chg;
    logic [TW-1:0] to_q;
    logic          unused_mode_pulse;

    btn_edge #(.HOLD_SECS(HOLD_SECS), .REPEAT_EN(1'b0)) u_mode (
        .clk_1Hz    (clk_1Hz),
        .rstn_i     (rstn_i),
        .btn_i      (mode_i),
        .hold_clr_i (1'b0),
        .edge_o     (mode_e),
        .pulse_o    (unused_mode_pulse)
    );

    btn_edge #(.HOLD_SECS(HOLD_SECS), .REPEAT_EN(1'b1)) u_inc (
        .clk_1Hz    (clk_1Hz),
        .rstn_i     (rstn_i),
        .btn_i      (inc_i),
        .hold_clr_i (state_chg),
        .edge_o     (inc_e),
        .pulse_o    (inc_p)
    );

    // A button edge in the same tick always defers the timeout.
    assign timeout_hit = (state_q != RUN) && !mode_e && !inc_e && (to_q == TW'(TIMEOUT_SECS - 1));
    assign state_chg   = mode_e || timeout_hit;
    assign state_nxt   = timeout_hit ? RUN : (mode_e ? next_mode(state_q) : state_q);
    assign state_o     = state_q;

    always_ff @(posedge clk_1Hz or negedge rstn_i) begin
        if (!rstn_i) begin
            to_q <= '0;
        end else if (state_q == RUN || mode_e || inc_e || timeout_hit) begin
            to_q <= '0;
        end else begin
            to_q <= to_q + TW'(1);
        end
    end

    always_ff @(posedge clk_1Hz or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= RUN;
            sec_en_o   <= 1'b1;
            sec_clr_o  <= 1'b0;
            inc_min_o  <= 1'b0;
            inc_hour_o <= 1'b0;
            blink_o    <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            sec_en_o   <= (state_nxt == RUN);
            sec_clr_o  <= (state_q != RUN) && (state_nxt == RUN);
            blink_o    <= ((state_q != RUN) && (state_nxt != RUN)) ? ~blink_o : 1'b0;
            inc_min_o  <= 1'b0;
            inc_hour_o <= 1'b0;
            // Increment strobes are suppressed in any tick that changes state.
            if (!state_chg) begin
                case (state_q)
                    RUN:      inc_min_o  <= inc_min_i;
                    SET_HOUR: inc_hour_o <= inc_p;
                    SET_MIN:  inc_min_o  <= inc_p;
                    default:  ;
                endcase
            end
        end
    end

`ifdef RELOGIO_ALARM_EN
    logic [4:0] al_h_q;
    logic [5:0] al_m_q;
    logic       ack_q;
    logic       al_match;

    assign al_match = (horas_i == al_h_q) && (minutos_i == al_m_q);

    always_ff @(posedge clk_1Hz or negedge rstn_i) begin
        if (!rstn_i) begin
            al_h_q  <= '0;
            al_m_q  <= '0;
            ack_q   <= 1'b0;
            alarm_o <= 1'b0;
        end else begin
            if (!state_chg && inc_p && state_q == SET_AL_HOUR) begin
                al_h_q <= (al_h_q == MAX_HORA) ? 5'd0 : al_h_q + 5'd1;
            end
            if (!state_chg && inc_p && state_q == SET_AL_MIN) begin
                al_m_q <= (al_m_q == MAX_MIN) ? 6'd0 : al_m_q + 6'd1;
            end
            // Acknowledge holds until the match drops, then the alarm re-arms.
            if (!al_match) begin
                ack_q <= 1'b0;
            end else if (mode_e || inc_e) begin
                ack_q <= 1'b1;
            end
            alarm_o <= (state_q == RUN) && al_match && !ack_q && !(mode_e || inc_e);
        end
    end
`else
    logic unused_time;
    assign unused_time = ^{minutos_i, horas_i};
    assign alarm_o     = 1'b0;
`endif

endmodule

// File: tb/tb_relogio_ctrl.sv
// Self-checking bench for relogio_ctrl; follows RELOGIO_ALARM_EN when defined.
module tb_relogio_ctrl;

    localparam int HOLD    = 2;
    localparam int TIMEOUT = 30;
    localparam logic [2:0] S_RUN      = 3'd0;
    localparam logic [2:0] S_SET_HOUR = 3'd1;
    localparam logic [2:0] S_SET_MIN  = 3'd2;

    logic       clk_1Hz = 1'b0;
    logic       rstn_i;
    logic       mode_i;
    logic       inc_i;
    logic       inc_min_i;
    logic [5:0] minutos_i;
    logic [4:0] horas_i;
    logic       sec_en_o;
    logic       sec_clr_o;
    logic       inc_min_o;
    logic       inc_hour_o;
    logic [2:0] state_o;
    logic       blink_o;
    logic       alarm_o;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_next  = 0;
    int n_min   = 0;
    int n_hour  = 0;

    // Cycle numbers (posedge index) at which each strobe is expected.
    logic [31:0] min_exp_q[$];
    logic [31:0] hour_exp_q[$];
    logic [31:0] clr_exp_q[$];

    relogio_ctrl #(.HOLD_SECS(HOLD), .TIMEOUT_SECS(TIMEOUT)) dut (
        .clk_1Hz    (clk_1Hz),
        .rstn_i     (rstn_i),
        .mode_i     (mode_i),
        .inc_i      (inc_i),
        .inc_min_i  (inc_min_i),
        .minutos_i  (minutos_i),
        .horas_i    (horas_i),
        .sec_en_o   (sec_en_o),
        .sec_clr_o  (sec_clr_o),
        .inc_min_o  (inc_min_o),
        .inc_hour_o (inc_hour_o),
        .state_o    (state_o),
        .blink_o    (blink_o),
        .alarm_o    (alarm_o)
    );

    always #5 clk_1Hz = ~clk_1Hz;
    always @(posedge clk_1Hz) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Inputs change on the falling edge; n_next is the rising edge that samples them.
    task automatic tick(input logic m, input logic i, input logic c);
        @(negedge clk_1Hz);
        mode_i    = m;
        inc_i     = i;
        inc_min_i = c;
        n_next    = cyc + 1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1'b0, 1'b0, 1'b0);
    endtask

    task automatic mode_press();
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
    endtask

    task automatic leave_set_min();
`ifdef RELOGIO_ALARM_EN
        mode_press();
        mode_press();
`endif
        tick(1'b1, 1'b0, 1'b0);
        clr_exp_q.push_back(n_next + 1);
        tick(1'b0, 1'b0, 1'b0);
        idle(2);
    endtask

    always @(negedge clk_1Hz) begin
        if (rstn_i) begin
            if (inc_min_o) n_min++;
            if (inc_hour_o) n_hour++;
            if (min_exp_q.size() > 0 && min_exp_q[0] == cyc) begin
                void'(min_exp_q.pop_front());
                check("inc_min_pulse", inc_min_o, 1'b1);
            end else if (inc_min_o) begin
                check("inc_min_unexpected", inc_min_o, 1'b0);
            end
            if (hour_exp_q.size() > 0 && hour_exp_q[0] == cyc) begin
                void'(hour_exp_q.pop_front());
                check("inc_hour_pulse", inc_hour_o, 1'b1);
            end else if (inc_hour_o) begin
                check("inc_hour_unexpected", inc_hour_o, 1'b0);
            end
            if (clr_exp_q.size() > 0 && clr_exp_q[0] == cyc) begin
                void'(clr_exp_q.pop_front());
                check("sec_clr_pulse", sec_clr_o, 1'b1);
            end else if (sec_clr_o) begin
                check("sec_clr_unexpected", sec_clr_o, 1'b0);
            end
            if (inc_min_o || inc_hour_o) check("inc_exclusive", inc_min_o & inc_hour_o, 1'b0);
        end
    end

    initial begin
        int base;
        int drops;
        int entry;
        logic b_a;
        logic b_b;

        rstn_i    = 1'b0;
        mode_i    = 1'b0;
        inc_i     = 1'b0;
        inc_min_i = 1'b0;
        minutos_i = 6'd0;
        horas_i   = 5'd12;

        // Reset values
        @(negedge clk_1Hz);
        check("rst_state", state_o, S_RUN);
        check("rst_sec_en", sec_en_o, 1'b1);
        check("rst_sec_clr", sec_clr_o, 1'b0);
        check("rst_inc_min", inc_min_o, 1'b0);
        check("rst_inc_hour", inc_hour_o, 1'b0);
        check("rst_blink", blink_o, 1'b0);
        check("rst_alarm", alarm_o, 1'b0);
        @(negedge clk_1Hz);
        rstn_i = 1'b1;

        // 1: RUN passes the seconds carry one tick later
        base  = n_min;
        drops = 0;
        for (int k = 0; k < 130; k++) begin
            tick(1'b0, 1'b0, (k % 60) == 59);
            if (inc_min_i) min_exp_q.push_back(n_next);
            if (!sec_en_o) drops++;
        end
        idle(3);
        check("t1_sec_en_drops", drops, 0);
        check("t1_inc_min_count", n_min - base, 2);

        // 2: SET_HOUR with three increments, then back to RUN
        mode_press();
        idle(1);
        base = n_hour;
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, 1'b1, 1'b0);
            hour_exp_q.push_back(n_next + 1);
            tick(1'b0, 1'b0, 1'b0);
        end
        idle(2);
        check("t2_state_hour", state_o, S_SET_HOUR);
        check("t2_sec_en", sec_en_o, 1'b0);
        check("t2_hour_count", n_hour - base, 3);
        mode_press();
        idle(1);
        check("t2_state_min", state_o, S_SET_MIN);
        leave_set_min();
        check("t2_state_run", state_o, S_RUN);
        check("t2_sec_en_back", sec_en_o, 1'b1);

        // 3: hold inc for 6 ticks in SET_MIN
        mode_press();
        mode_press();
        idle(1);
        check("t3_state_min", state_o, S_SET_MIN);
        base = n_min;
        for (int j = 0; j < 6; j++) begin
            tick(1'b0, 1'b1, 1'b0);
            if (j == 0 || j >= HOLD) min_exp_q.push_back(n_next + 1);
        end
        idle(3);
        check("t3_hold_pulses", n_min - base, 5);
        leave_set_min();
        check("t3_state_run", state_o, S_RUN);

        // 4: SET_HOUR timeout; carries in SET are swallowed
        tick(1'b1, 1'b0, 1'b0);
        entry = n_next;
        b_a = 1'b0;
        b_b = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            tick(1'b0, 1'b0, (k == 5) || (k == 20));
            if (k == 10) b_a = blink_o;
            if (k == 11) b_b = blink_o;
        end
        check("t4_blink_toggle", b_a ^ b_b, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
        check("t4_before_timeout", state_o, S_SET_HOUR);
        clr_exp_q.push_back(entry + TIMEOUT + 1);
        tick(1'b0, 1'b0, 1'b0);
        check("t4_timeout_run", state_o, S_RUN);
        check("t4_sec_en", sec_en_o, 1'b1);
        check("t4_blink_off", blink_o, 1'b0);
        idle(2);

        // 5: mode beats inc; reset mid-SET_MIN drops a pending pulse
        mode_press();
        idle(1);
        base = n_hour;
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        idle(2);
        check("t5_mode_wins_state", state_o, S_SET_MIN);
        check("t5_no_hour_pulse", n_hour - base, 0);
        tick(1'b0, 1'b1, 1'b0);
        @(negedge clk_1Hz);
        rstn_i = 1'b0;
        inc_i  = 1'b0;
        #1;
        check("t5_rst_state", state_o, S_RUN);
        check("t5_rst_sec_en", sec_en_o, 1'b1);
        check("t5_rst_inc_min", inc_min_o, 1'b0);
        check("t5_rst_blink", blink_o, 1'b0);
        @(negedge clk_1Hz);
        rstn_i = 1'b1;
        idle(3);
        check("t5_after_rst_state", state_o, S_RUN);
        // inc is ignored in RUN
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        idle(2);
        check("t5_run_inc_ignored", state_o, S_RUN);

`ifdef RELOGIO_ALARM_EN
        // 6: set alarm to 07:30, then match / acknowledge / re-arm
        mode_press();
        mode_press();
        mode_press();
        for (int k = 0; k < 7; k++) begin
            tick(1'b0, 1'b1, 1'b0);
            tick(1'b0, 1'b0, 1'b0);
        end
        mode_press();
        for (int k = 0; k < 30; k++) begin
            tick(1'b0, 1'b1, 1'b0);
            tick(1'b0, 1'b0, 1'b0);
        end
        tick(1'b1, 1'b0, 1'b0);
        clr_exp_q.push_back(n_next + 1);
        tick(1'b0, 1'b0, 1'b0);
        idle(2);
        check("t6_state_run", state_o, S_RUN);
        check("t6_no_match", alarm_o, 1'b0);
        horas_i   = 5'd7;
        minutos_i = 6'd30;
        idle(3);
        check("t6_alarm_on", alarm_o, 1'b1);
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        idle(2);
        check("t6_alarm_ack", alarm_o, 1'b0);
        minutos_i = 6'd31;
        idle(3);
        check("t6_alarm_mismatch", alarm_o, 1'b0);
        minutos_i = 6'd30;
        idle(3);
        check("t6_alarm_rearm", alarm_o, 1'b1);
`else
        horas_i   = 5'd0;
        minutos_i = 6'd0;
        idle(3);
        check("t6_alarm_tied0", alarm_o, 1'b0);
`endif

        idle(3);
        check("min_exp_left", min_exp_q.size(), 0);
        check("hour_exp_left", hour_exp_q.size(), 0);
        check("clr_exp_left", clr_exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
